// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq/j)
// One shared req/ack memory port serves both instruction fetch and data access.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int NREGS  = 32,
  parameter int DISP_W = 8,
  localparam int AW  = $clog2(NREGS),
  localparam int SLW = (DISP_W >= 32) ? 1 : $clog2(32 / DISP_W)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic [AW-1:0]     dbg_sel,
  input  logic [SLW-1:0]    dbg_slice,
  output logic [DISP_W-1:0] dbg_data,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic        fetch_pending;
  logic [31:0] regs [NREGS];

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [AW-1:0] rs_idx;
  logic [AW-1:0] rt_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] dest_idx;
  logic [31:0]   imm_sext;
  logic [31:0]   pc_plus4;
  logic [31:0]   jump_target;
  logic [31:0]   branch_target;
  logic          funct_ok;
  logic          is_legal;
  logic [31:0]   alu_result;
  logic [31:0]   wb_value;
  logic [31:0]   dbg_shift;

  assign pc_out = pc;

  always_comb begin
    opcode        = ir[31:26];
    funct         = ir[5:0];
    rs_idx        = ir[21 +: AW];
    rt_idx        = ir[16 +: AW];
    rd_idx        = ir[11 +: AW];
    imm_sext      = {{16{ir[15]}}, ir[15:0]};
    pc_plus4      = pc + 32'd4;
    jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
    branch_target = pc_plus4 + (imm_sext << 2);
    dest_idx      = (opcode == OP_R) ? rd_idx : rt_idx;
    wb_value      = (opcode == OP_LW) ? mdr : alu_out;
    funct_ok      = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
    is_legal      = 1'b0;
    case (opcode)
      OP_R:                                    is_legal = funct_ok;
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW:     is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  end

  // Non-R-type ALU users (addi, lw, sw address) all need rs + sext(imm).
  always_comb begin
    alu_result = a_reg + imm_sext;
    if (opcode == OP_R) begin
      case (funct)
        FN_SUB:  alu_result = a_reg - b_reg;
        FN_AND:  alu_result = a_reg & b_reg;
        FN_OR:   alu_result = a_reg | b_reg;
        FN_SLT:  alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
        default: alu_result = a_reg + b_reg;
      endcase
    end
  end

  // Memory port is combinational from state so a zero-wait memory accepts in the same cycle;
  // gating with reset_n makes an asynchronous reset drop the request immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          if (run || fetch_pending) begin
            mem_req  = 1'b1;
            mem_addr = pc;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_addr = alu_out;
          if (opcode == OP_SW) begin
            mem_we    = 1'b1;
            mem_wdata = b_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_req && mem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (!is_legal || opcode == OP_J) state_next = S_FETCH;
        else                             state_next = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_BEQ)                         state_next = S_FETCH;
        else if (opcode == OP_LW || opcode == OP_SW)  state_next = S_MEM;
        else                                          state_next = S_WB;
      end
      S_MEM: begin
        if (mem_ack) state_next = (opcode == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      ir            <= 32'd0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      alu_out       <= 32'd0;
      mdr           <= 32'd0;
      fetch_pending <= 1'b0;
      retire        <= 1'b0;
      illegal       <= 1'b0;
      dbg_data      <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
    end else begin
      retire   <= 1'b0;
      illegal  <= 1'b0;
      dbg_data <= DISP_W'(regs[dbg_sel] >> dbg_shift);
      case (state)
        S_FETCH: begin
          // Once a fetch is requested it stays requested even if run drops.
          fetch_pending <= mem_req && !mem_ack;
          if (mem_req && mem_ack) ir <= mem_rdata;
        end
        S_DECODE: begin
          a_reg <= regs[rs_idx];
          b_reg <= regs[rt_idx];
          if (!is_legal) begin
            illegal <= 1'b1;
            retire  <= 1'b1;
            pc      <= pc_plus4;
          end else if (opcode == OP_J) begin
            retire <= 1'b1;
            pc     <= jump_target;
          end
        end
        S_EXEC: begin
          alu_out <= alu_result;
          if (opcode == OP_BEQ) begin
            retire <= 1'b1;
            pc     <= (a_reg == b_reg) ? branch_target : pc_plus4;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (opcode == OP_SW) begin
              retire <= 1'b1;
              pc     <= pc_plus4;
            end else begin
              mdr <= mem_rdata;
            end
          end
        end
        S_WB: begin
          if (dest_idx != '0) regs[dest_idx] <= wb_value;
          retire <= 1'b1;
          pc     <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbg_shift = 32'(dbg_slice) * 32'(DISP_W);
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  dbg_sel = 5'd0;
  logic [1:0]  dbg_slice = 2'd0;
  logic [7:0]  dbg_data;
  logic [31:0] pc_out;
  logic        retire;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mips_multicycle_core dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_sel   (dbg_sel),
    .dbg_slice (dbg_slice),
    .dbg_data  (dbg_data),
    .pc_out    (pc_out),
    .retire    (retire),
    .illegal   (illegal)
  );

  // Program image is written only by the stimulus; stores land in a separate overlay.
  logic [31:0] mem    [0:127];
  logic [31:0] st_mem [0:127];
  logic [127:0] st_valid;
  int ack_delay = 0;
  int wait_cnt;
  int wr_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_log [0:63];
  int rd_n;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = st_valid[mem_addr[8:2]] ? st_mem[mem_addr[8:2]] : mem[mem_addr[8:2]];

  always @(posedge CLK) begin
    if (!reset_n) begin
      wait_cnt <= 0;
      st_valid <= '0;
      wr_cnt   <= 0;
      rd_n     <= 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      if (mem_we) begin
        st_mem[mem_addr[8:2]]   <= mem_wdata;
        st_valid[mem_addr[8:2]] <= 1'b1;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else begin
        if (rd_n < 64) rd_log[rd_n] <= mem_addr;
        rd_n <= rd_n + 1;
      end
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  int cyc;
  int ret_n;
  int ill_n;
  int ret_cyc [0:63];

  always @(negedge CLK) begin
    if (!reset_n) begin
      cyc   <= 0;
      ret_n <= 0;
      ill_n <= 0;
    end else begin
      cyc <= cyc + 1;
      if (retire) begin
        if (ret_n < 64) ret_cyc[ret_n] <= cyc;
        ret_n <= ret_n + 1;
      end
      if (illegal) ill_n <= ill_n + 1;
    end
  end

  logic        p_hold = 1'b0;
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        stab_bad = 1'b0;

  always @(negedge CLK) begin
    if (p_hold && reset_n &&
        (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
      stab_bad <= 1'b1;
    p_hold  <= mem_req && !mem_ack && reset_n;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_retires(input int n, input int budget);
    int k;
    k = 0;
    while (ret_n < n && k < budget) begin
      tick();
      k++;
    end
    check("retire_budget", 32'(ret_n >= n), 32'd1);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    v = 32'd0;
    for (int s = 0; s < 4; s++) begin
      dbg_sel   = r;
      dbg_slice = 2'(s);
      tick();
      tick();
      v[s*8 +: 8] = dbg_data;
    end
  endtask

  initial begin
    logic [31:0] v;
    int k;
    logic seen;

    // Arithmetic program; also covers reset/idle behaviour
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem[4] = enc_j(26'd4);
    ack_delay = 0;
    do_reset();
    repeat (5) tick();
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_pc", pc_out, 32'h0);
    check("rst_dbg", 32'(dbg_data), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    run = 1'b1;
    #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0);
    wait_retires(5, 200);
    check("gap_01", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("gap_12", 32'(ret_cyc[2] - ret_cyc[1]), 32'd4);
    check("gap_23", 32'(ret_cyc[3] - ret_cyc[2]), 32'd4);
    read_reg(5'd3, v);
    check("add_r3", v, 32'd2);
    read_reg(5'd4, v);
    check("slt_r4", v, 32'd1);
    dbg_sel   = 5'd3;
    dbg_slice = 2'd0;
    tick();
    tick();
    check("dbg_r3", 32'(dbg_data), 32'h02);

    // Store then load with three wait cycles per access
    clear_mem();
    mem[0]  = enc_j(26'd8);
    mem[2]  = 32'hDEAD_BEEF;
    mem[8]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[9]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem[10] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    mem[11] = enc_j(26'd11);
    ack_delay = 3;
    do_reset();
    run = 1'b1;
    wait_retires(5, 400);
    check("sw_count", 32'(wr_cnt), 32'd1);
    check("sw_addr", wr_addr, 32'd8);
    check("sw_data", wr_data, 32'd5);
    read_reg(5'd5, v);
    check("lw_r5", v, 32'd5);
    check("req_stable", 32'(stab_bad), 32'd0);

    // Control flow, $0 writes, illegal funct, overflow wrap
    clear_mem();
    mem[0]   = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    mem[1]   = enc_i(6'h08, 5'd0, 5'd2, 16'd9);
    mem[2]   = enc_i(6'h08, 5'd0, 5'd0, 16'd1);
    mem[3]   = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
    mem[4]   = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem[5]   = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    mem[6]   = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    mem[7]   = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    mem[8]   = enc_j(26'h40);
    mem[64]  = 32'h0000_0000;
    mem[65]  = enc_i(6'h23, 5'd0, 5'd11, 16'h01F0);
    mem[66]  = enc_i(6'h08, 5'd0, 5'd12, 16'd1);
    mem[67]  = enc_r(5'd11, 5'd12, 5'd13, 6'h20);
    mem[68]  = enc_j(26'd68);
    mem[124] = 32'h7FFF_FFFF;
    ack_delay = 0;
    do_reset();
    run = 1'b1;
    wait_retires(13, 400);
    check("beq_taken", rd_log[5], 32'h1C);
    check("beq_not", rd_log[6], 32'h20);
    check("jump", rd_log[7], 32'h100);
    check("illegal_pc", rd_log[8], 32'h104);
    check("illegal_cnt", 32'(ill_n), 32'd1);
    read_reg(5'd0, v);
    check("r0_zero", v, 32'd0);
    read_reg(5'd7, v);
    check("skip_r7", v, 32'd0);
    read_reg(5'd13, v);
    check("ovf_r13", v, 32'h8000_0000);

    // Reset in the middle of an lw ack wait
    clear_mem();
    mem[0]   = enc_i(6'h23, 5'd0, 5'd5, 16'h01F0);
    mem[1]   = enc_j(26'd1);
    mem[124] = 32'h7FFF_FFFF;
    ack_delay = 3;
    do_reset();
    run = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      tick();
      k++;
      if (mem_req && mem_addr == 32'h1F0 && !mem_ack) seen = 1'b1;
    end
    check("lw_wait_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    repeat (3) tick();
    run = 1'b0;
    reset_n = 1'b1;
    tick();
    read_reg(5'd5, v);
    check("rst_r5", v, 32'd0);
    check("rst_pc", pc_out, 32'h0);
    run = 1'b1;
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle MIPS datapath: same instruction subset plus `addi`. Each instruction is sequenced by a FETCH/DECODE/EXEC/MEM/WB state machine over one shared memory port with a req/ack handshake, so memories of any latency can be attached. Register-file depth, reset vector and debug-readout width are parameters. The block sits between the board-level top (switches/LEDs) and a unified instruction/data memory.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NREGS`, 32, register-file entries (power of 2, 8..32); register 0 reads zero
- `DISP_W`, 8, debug readout width; one of 4, 8, 16, 32
- `CLK` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `run` in 1: sampled only in FETCH before a request; 0 holds the core idle
- `mem_req` out 1: memory request; held until accepted
- `mem_we` out 1: 1 = write (sw), 0 = read (fetch/lw)
- `mem_addr` out 32: byte address
- `mem_wdata` out 32: store data
- `mem_rdata` in 32: read data, valid on the accept cycle
- `mem_ack` in 1: accept; a transfer completes on any rising edge with `mem_req` && `mem_ack`
- `dbg_sel` in $clog2(NREGS): register to display
- `dbg_slice` in max(1,$clog2(32/DISP_W)): slice index
- `dbg_data` out DISP_W: `reg[dbg_sel][dbg_slice*DISP_W +: DISP_W]`, registered
- `pc_out` out 32: current PC
- `retire` out 1: one-cycle pulse when an instruction completes
- `illegal` out 1: one-cycle pulse on an unsupported opcode/funct

## Operation
- Reset values: PC = `RESET_PC`, state FETCH, all registers 0, `mem_req` = `mem_we` = 0, `mem_addr` = `mem_wdata` = 0, `dbg_data` = 0, `retire` = `illegal` = 0.
- FETCH: if `run`, drive `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On accept, latch IR and go to DECODE.
- DECODE: read rs/rt; sign-extend imm16. Compute PC+4.
  - `j` (000010): PC = {PC+4[31:28], IR[25:0], 2'b00}, retire, go to FETCH.
  - Unsupported opcode: pulse `illegal` and `retire`, PC = PC+4, go to FETCH; no register or memory write.
- EXEC: ALU operation.
  - R-type (000000), funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Any other funct is illegal, handled as in DECODE.
  - `addi` (001000): rs + sext(imm).
  - `lw` (100011) / `sw` (101011): address = rs + sext(imm), then go to MEM.
  - `beq` (000100): if rs == rt, PC = PC+4 + (sext(imm)<<2), else PC+4. Retire, go to FETCH.
  - R-type and `addi` go to WB.
- MEM: drive `mem_req`=1, `mem_addr` = computed address (low 2 bits passed unchanged). For `sw`, also `mem_we`=1 and `mem_wdata`=rt.
  - On accept: `sw` retires, PC += 4, go to FETCH; `lw` latches `mem_rdata` and goes to WB.
- WB: write rd (R-type) or rt (`addi`/`lw`). Writes to reg 0 are discarded. PC += 4, retire, go to FETCH.
- Arithmetic is 32-bit two's complement; overflow wraps with no trap. The PC wraps modulo 2^32.
- Register indices ≥ NREGS are truncated to $clog2(NREGS) bits.

## Timing
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high. `mem_req` drops the cycle after the accept.
- With `mem_ack` tied high, cycle counts per instruction are:
  - `j` / illegal: 2
  - `beq`: 3
  - R-type / `addi` / `sw`: 4
  - `lw`: 5
- Each ack wait cycle adds one cycle.
- Register writes become visible to the next instruction's DECODE.
- `dbg_data` updates 1 cycle after `dbg_sel`/`dbg_slice` change or after a write to the selected register.
- `run` low in FETCH: no request and the PC holds. `run` is ignored in all other states.
- `reset_n` asserted mid-transfer: `mem_req` drops immediately (asynchronous), and the memory abandons the transfer. The first request after release is a fetch from `RESET_PC`.

## Test plan
- Reset/idle: `reset_n`=0 then 1 with `run`=0 → `mem_req`=0 and `pc_out`=0 indefinitely. Set `run`=1 → fetch request at address 0 on the next cycle.
- Arithmetic: `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `slt $4,$2,$1` → $3=2, $4=1. `retire` pulses 4 cycles apart with ack tied high. `dbg_sel`=3, `dbg_slice`=0 → `dbg_data`=8'h02.
- Memory with waits: `sw $1,8($0)` then `lw $5,8($0)`, with ack delayed 3 cycles → write observed at address 8 with data 5, $5=5, and request signals stable throughout each wait.
- Control flow: `beq $1,$1,+2` at 0x10 → next fetch at 0x1C. `beq` not taken → next fetch at 0x14. `j 0x40` → next fetch at 0x100.
- Edge cases: write to $0 → $0 still reads 0. `add` of 0x7FFFFFFF+1 → 0x80000000. Funct 000000 → `illegal` pulse and PC+4.
- Reset mid-`lw` (during an ack wait) → `mem_req` low immediately, destination register unchanged, restart fetch at `RESET_PC`.
